// File: rtl/mem_ctrl_if.sv
// Bus bundle between the IF/MEM pipeline stages, the memory controller and
// the byte-wide unified RAM. The controller uses the slave modport; the
// pipeline/RAM side uses the master modport.
interface mem_ctrl_if;
  // Instruction fetch port
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_abort_i;
  logic [31:0] if_data_o;
  logic        if_done_o;

  // Load/store port
  logic        mem_req_i;
  logic        mem_we_i;
  logic [1:0]  mem_sel_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic [31:0] mem_rdata_o;
  logic        mem_done_o;
  logic        mem_stall_o;

  // Byte-wide RAM port
  logic [31:0] ram_addr_o;
  logic        ram_wr_o;
  logic [7:0]  ram_dout_o;
  logic [7:0]  ram_din_i;

  modport slave (
    input  if_req_i, if_addr_i, if_abort_i,
    output if_data_o, if_done_o,
    input  mem_req_i, mem_we_i, mem_sel_i, mem_addr_i, mem_wdata_i,
    output mem_rdata_o, mem_done_o, mem_stall_o,
    output ram_addr_o, ram_wr_o, ram_dout_o,
    input  ram_din_i
  );

  modport master (
    output if_req_i, if_addr_i, if_abort_i,
    input  if_data_o, if_done_o,
    output mem_req_i, mem_we_i, mem_sel_i, mem_addr_i, mem_wdata_i,
    input  mem_rdata_o, mem_done_o, mem_stall_o,
    input  ram_addr_o, ram_wr_o, ram_dout_o,
    output ram_din_i
  );
endinterface

// File: rtl/mem_ctrl.sv
// Single-port memory controller: shares a byte-wide RAM between instruction
// fetch and load/store. One transaction at a time, sequenced as consecutive
// byte accesses; read data is assembled little-endian and zero-extended.
module mem_ctrl (
  input  logic      clk,
  input  logic      rst,
  mem_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

  state_e      state_q, state_d;
  logic        own_mem_q, own_mem_d;    // 1 = MEM owns the transaction, 0 = IF
  logic [31:0] base_q, base_d;
  logic [2:0]  len_q, len_d;            // byte count N: 1, 2 or 4
  logic [2:0]  cnt_q, cnt_d;            // cycles elapsed since cycle 1
  logic [31:0] buf_q, buf_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] ram_addr_q, ram_addr_d;
  logic        ram_wr_q, ram_wr_d;
  logic [7:0]  ram_dout_q, ram_dout_d;
  logic [31:0] if_data_q, if_data_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;
  logic        if_done_q, if_done_d;
  logic        mem_done_q, mem_done_d;

  logic [2:0]  cnt_inc;
  logic [1:0]  cap_idx;
  logic [1:0]  nxt_idx;
  logic [2:0]  sel_len;
  logic [31:0] buf_cap;

  // Helpers: size decode and the buffer with this cycle's RAM byte merged in.
  // RAM data lags the address by one cycle, so in cycle c the byte for
  // index c-2 is on ram_din_i (cnt_q = c-1, capture index = cnt_q-1).
  always_comb begin
    cnt_inc = cnt_q + 3'd1;
    cap_idx = cnt_q[1:0] - 2'd1;
    nxt_idx = cnt_inc[1:0];
    unique case (bus.mem_sel_i)
      2'b00:   sel_len = 3'd1;
      2'b01:   sel_len = 3'd2;
      default: sel_len = 3'd4;
    endcase
    buf_cap = buf_q;
    if (cnt_q != 3'd0) begin
      buf_cap[{cap_idx, 3'b000} +: 8] = bus.ram_din_i;
    end
  end

  // Next-state logic for the transaction sequencer and its registered outputs.
  always_comb begin
    state_d     = state_q;
    own_mem_d   = own_mem_q;
    base_d      = base_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    buf_d       = buf_q;
    wdata_d     = wdata_q;
    ram_addr_d  = ram_addr_q;
    ram_wr_d    = 1'b0;
    ram_dout_d  = ram_dout_q;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        // MEM wins arbitration; the first byte address goes out on the accepting edge
        if (bus.mem_req_i) begin
          own_mem_d  = 1'b1;
          base_d     = bus.mem_addr_i;
          len_d      = sel_len;
          cnt_d      = 3'd0;
          buf_d      = 32'd0;
          wdata_d    = bus.mem_wdata_i;
          ram_addr_d = bus.mem_addr_i;
          if (bus.mem_we_i) begin
            state_d    = StWrite;
            ram_wr_d   = 1'b1;
            ram_dout_d = bus.mem_wdata_i[7:0];
          end else begin
            state_d = StRead;
          end
        end else if (bus.if_req_i && !bus.if_abort_i) begin
          own_mem_d  = 1'b0;
          base_d     = bus.if_addr_i;
          len_d      = 3'd4;
          cnt_d      = 3'd0;
          buf_d      = 32'd0;
          ram_addr_d = bus.if_addr_i;
          state_d    = StRead;
        end
      end

      StRead: begin
        if (!own_mem_q && bus.if_abort_i) begin
          // Branch flush kills the fetch; partial data is dropped
          state_d = StIdle;
        end else begin
          buf_d = buf_cap;
          if (cnt_q == len_q) begin
            state_d = StDone;
            if (own_mem_q) begin
              mem_rdata_d = buf_cap;
              mem_done_d  = 1'b1;
            end else begin
              if_data_d = buf_cap;
              if_done_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc < len_q) begin
              ram_addr_d = base_q + {29'd0, cnt_inc};
            end
          end
        end
      end

      StWrite: begin
        if (cnt_q == len_q - 3'd1) begin
          state_d    = StDone;
          mem_done_d = 1'b1;
        end else begin
          cnt_d      = cnt_inc;
          ram_wr_d   = 1'b1;
          ram_addr_d = base_q + {29'd0, cnt_inc};
          ram_dout_d = wdata_q[{nxt_idx, 3'b000} +: 8];
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers; reset clears everything, dropping ram_wr at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      own_mem_q   <= 1'b0;
      base_q      <= 32'd0;
      len_q       <= 3'd0;
      cnt_q       <= 3'd0;
      buf_q       <= 32'd0;
      wdata_q     <= 32'd0;
      ram_addr_q  <= 32'd0;
      ram_wr_q    <= 1'b0;
      ram_dout_q  <= 8'd0;
      if_data_q   <= 32'd0;
      mem_rdata_q <= 32'd0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      own_mem_q   <= own_mem_d;
      base_q      <= base_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      buf_q       <= buf_d;
      wdata_q     <= wdata_d;
      ram_addr_q  <= ram_addr_d;
      ram_wr_q    <= ram_wr_d;
      ram_dout_q  <= ram_dout_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
    end
  end

  assign bus.ram_addr_o  = ram_addr_q;
  assign bus.ram_wr_o    = ram_wr_q;
  assign bus.ram_dout_o  = ram_dout_q;
  assign bus.if_data_o   = if_data_q;
  assign bus.mem_rdata_o = mem_rdata_q;
  assign bus.mem_done_o  = mem_done_q;
  // An abort in the done cycle still suppresses the fetch completion
  assign bus.if_done_o   = if_done_q & ~bus.if_abort_i;
  assign bus.mem_stall_o = bus.mem_req_i & ~mem_done_q;

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Single-port memory controller that shares the byte-wide unified RAM between instruction fetch (IF) and the load/store path (MEM). It accepts at most one word/half/byte transaction at a time and sequences it as consecutive byte accesses. It assembles read data little-endian and signals completion with a one-cycle done pulse. It sits between the IF/MEM pipeline stages and the RAM, and supplies the stall that holds the pipeline during load/store.

## Interface
- No parameters; data and address width 32, RAM data width 8.
- Reset: one clock; reset is asynchronous and active-high.
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-high reset (`RstEnable` = 1)
- `if_req_i`  in  1  fetch request, held high until `if_done_o` or abort
- `if_addr_i`  in  32  fetch address
- `if_abort_i`  in  1  branch flush; kills the in-flight or pending fetch
- `if_data_o`  out  32  fetched instruction word
- `if_done_o`  out  1  one-cycle pulse, `if_data_o` valid
- `mem_req_i`  in  1  load/store request, held until `mem_done_o`
- `mem_we_i`  in  1  1 = store, 0 = load
- `mem_sel_i`  in  2  size: 00 byte, 01 half, 10/11 word
- `mem_addr_i`  in  32  data address
- `mem_wdata_i`  in  32  store data; low bytes used
- `mem_rdata_o`  out  32  load data, zero-extended (sign extension is done in MEM)
- `mem_done_o`  out  1  one-cycle pulse
- `mem_stall_o`  out  1  `mem_req_i & ~mem_done_o` (combinational)
- `ram_addr_o`  out  32  RAM byte address
- `ram_wr_o`  out  1  RAM write strobe
- `ram_dout_o`  out  8  RAM write data
- `ram_din_i`  in  8  RAM read data; valid one cycle after the address

## Operation
- States: IDLE, READ, WRITE, DONE. Registers: owner (IF/MEM), base address, byte count N (1/2/4), address index, capture index, data buffer.
- IDLE: samples requests on each edge. Arbitration:
  - `mem_req_i` has priority over `if_req_i`.
  - IF is accepted only if `if_abort_i` = 0.
  - A load or fetch goes to READ; a store goes to WRITE.
- READ: address index i runs 0..N-1, one per cycle, with `ram_addr_o` = base+i.
  - Byte captured at the end of the cycle after its address goes into buffer[8k+7:8k].
  - After the last capture, go to DONE.
- WRITE: each cycle drives `ram_addr_o` = base+i, `ram_dout_o` = wdata[8i+7:8i] and `ram_wr_o` = 1, for i = 0..N-1, then goes to DONE.
- DONE: exactly one cycle.
  - Asserts the owner's done.
  - `if_done_o` = DONE & owner=IF & ~`if_abort_i`.
  - Data output is registered and holds until the next transaction of the same owner completes.
  - Requests are not sampled in DONE; the next state is IDLE.
- Abort: `if_abort_i` high during an IF-owned READ or DONE makes the next state IDLE with no done pulse. It has no effect on MEM transactions.
- Address arithmetic is 32-bit modulo: 0xFFFFFFFF+1 = 0x00000000.
- Unselected upper bytes of `mem_rdata_o` are 0.
- Transactions are never preempted; a MEM request arriving during a fetch waits.

## Timing
- Reset value of every output is 0: `ram_addr_o`, `ram_wr_o`, `ram_dout_o`, `if_data_o`, `mem_rdata_o`, both dones. State goes to IDLE.
- Reset mid-transaction drops `ram_wr_o` immediately; the partial transaction is discarded.
- Count cycles as 1, 2, ... after the accepting edge.
- Read of N bytes:
  - Addresses appear in cycles 1..N.
  - Captures happen at the ends of cycles 2..N+1.
  - Done is in cycle N+2, so a word fetch completes in cycle 6.
- Write of N bytes: writes in cycles 1..N, done in cycle N+1.
- Minimum gap: after DONE, one IDLE cycle before the next transaction's cycle 1.
- `ram_wr_o` is never high outside WRITE.
- `ram_addr_o` holds its last value in IDLE/DONE.

## Test plan
- IF word fetch at 0x00001000, RAM bytes 0x13, 0x05, 0x50, 0x00 -> addresses 0x1000..0x1003 in cycles 1–4, `if_done_o` in cycle 6, `if_data_o` = 0x00500513.
- `if_req_i` and `mem_req_i` (load byte at 0x40, RAM 0xFF) together -> MEM served first: `mem_rdata_o` = 0x000000FF, done in cycle 3. IF then starts and completes after the IDLE gap.
- Store half 0x1234ABCD at 0x20 -> writes 0xCD@0x20 in cycle 1 and 0xAB@0x21 in cycle 2, `mem_done_o` in cycle 3, `mem_stall_o` low from cycle 3.
- Abort fetch in cycle 3 -> state IDLE next edge, `if_done_o` never pulses. A new fetch to the target address is accepted on the following IDLE edge.
- Load word at 0xFFFFFFFE -> addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000, 0x00000001.
- Assert `rst` in cycle 2 of a word store -> `ram_wr_o` = 0 asynchronously, all outputs 0, no done. The first request after reset release is served normally.
